// File: rtl/instr_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register: single-outstanding
// imem handshake, decode redirects, and interrupt entry at instruction boundaries.
module instr_fetch #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] INT_VEC   = 32'h0000_0010,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_in,
    input  logic        branch_sel,
    input  logic [31:0] branch_pc,
    input  logic        irq,
    input  logic        returni,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] pc_plus_4,
    output logic [31:0] instr,
    output logic        interrupt,
    output logic        if_valid,
    output logic        int_en
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_imem_req;
    logic [31:0] r_imem_addr;
    logic [31:0] r_hold_word;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus_4;
    logic        r_interrupt;
    logic        r_if_valid;
    logic        r_int_en;
    logic        r_redirect_pending;
    logic [31:0] r_redirect_pc;

    state_t      w_next_state;
    logic [31:0] w_imem_addr;
    logic [31:0] w_hold_word;
    logic [31:0] w_instr;
    logic [31:0] w_pc_plus_4;
    logic        w_interrupt;
    logic        w_if_valid;
    logic        w_int_en;
    logic        w_redirect_pending;
    logic [31:0] w_redirect_pc;
    logic        w_branch_taken;
    logic        w_irq_take;
    logic [31:0] w_addr_inc;

    assign w_branch_taken = branch_sel & ~stall_in;
    // Interrupt decisions use the enable flag as it stood before any returni this cycle.
    assign w_irq_take     = irq & r_int_en;
    assign w_addr_inc     = r_imem_addr + 32'd4;

    // Next-state, fetch-address and IF/ID update logic.
    always_comb begin
        w_next_state       = r_state;
        w_imem_addr        = r_imem_addr;
        w_hold_word        = r_hold_word;
        w_instr            = r_instr;
        w_pc_plus_4        = r_pc_plus_4;
        w_interrupt        = r_interrupt;
        w_if_valid         = r_if_valid;
        w_redirect_pending = r_redirect_pending;
        w_redirect_pc      = r_redirect_pc;
        w_int_en           = returni ? 1'b1 : r_int_en;

        if (!stall_in) begin
            w_instr     = NOP_INSTR;
            w_if_valid  = 1'b0;
            w_interrupt = 1'b0;
        end else begin
            w_instr     = r_instr;
            w_if_valid  = r_if_valid;
            w_interrupt = r_interrupt;
        end

        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_FETCH;
                if (w_branch_taken) begin
                    w_imem_addr = branch_pc;
                end else begin
                    w_imem_addr = r_imem_addr;
                end
            end

            ST_FETCH: begin
                if (w_branch_taken) begin
                    if (imem_valid) begin
                        w_imem_addr        = branch_pc;
                        w_redirect_pending = 1'b0;
                    end else begin
                        // Address must stay stable until the outstanding response returns.
                        w_redirect_pending = 1'b1;
                        w_redirect_pc      = branch_pc;
                    end
                    w_next_state = ST_FETCH;
                end else if (imem_valid) begin
                    if (r_redirect_pending) begin
                        w_imem_addr        = r_redirect_pc;
                        w_redirect_pending = 1'b0;
                        w_next_state       = ST_FETCH;
                    end else if (w_irq_take) begin
                        w_instr      = NOP_INSTR;
                        w_pc_plus_4  = r_imem_addr;
                        w_interrupt  = 1'b1;
                        w_if_valid   = 1'b1;
                        w_imem_addr  = INT_VEC;
                        w_int_en     = 1'b0;
                        w_next_state = ST_FETCH;
                    end else if (stall_in) begin
                        w_hold_word  = imem_rdata;
                        w_next_state = ST_HOLD;
                    end else begin
                        w_instr      = imem_rdata;
                        w_pc_plus_4  = w_addr_inc;
                        w_interrupt  = 1'b0;
                        w_if_valid   = 1'b1;
                        w_imem_addr  = w_addr_inc;
                        w_next_state = ST_FETCH;
                    end
                end else begin
                    w_next_state = ST_FETCH;
                end
            end

            ST_HOLD: begin
                if (w_branch_taken) begin
                    w_imem_addr  = branch_pc;
                    w_next_state = ST_FETCH;
                end else if (stall_in) begin
                    w_next_state = ST_HOLD;
                end else if (w_irq_take) begin
                    w_instr      = NOP_INSTR;
                    w_pc_plus_4  = r_imem_addr;
                    w_interrupt  = 1'b1;
                    w_if_valid   = 1'b1;
                    w_imem_addr  = INT_VEC;
                    w_int_en     = 1'b0;
                    w_next_state = ST_FETCH;
                end else begin
                    w_instr      = r_hold_word;
                    w_pc_plus_4  = w_addr_inc;
                    w_interrupt  = 1'b0;
                    w_if_valid   = 1'b1;
                    w_imem_addr  = w_addr_inc;
                    w_next_state = ST_FETCH;
                end
            end

            default: begin
                w_next_state       = ST_IDLE;
                w_redirect_pending = 1'b0;
            end
        endcase
    end

    // State, fetch and IF/ID registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= ST_IDLE;
            r_imem_req         <= 1'b0;
            r_imem_addr        <= RESET_VEC;
            r_hold_word        <= NOP_INSTR;
            r_instr            <= NOP_INSTR;
            r_pc_plus_4        <= 32'd0;
            r_interrupt        <= 1'b0;
            r_if_valid         <= 1'b0;
            r_int_en           <= 1'b1;
            r_redirect_pending <= 1'b0;
            r_redirect_pc      <= 32'd0;
        end else begin
            r_state            <= w_next_state;
            r_imem_req         <= (w_next_state == ST_FETCH);
            r_imem_addr        <= w_imem_addr;
            r_hold_word        <= w_hold_word;
            r_instr            <= w_instr;
            r_pc_plus_4        <= w_pc_plus_4;
            r_interrupt        <= w_interrupt;
            r_if_valid         <= w_if_valid;
            r_int_en           <= w_int_en;
            r_redirect_pending <= w_redirect_pending;
            r_redirect_pc      <= w_redirect_pc;
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_imem_addr;
    assign pc_plus_4 = r_pc_plus_4;
    assign instr     = r_instr;
    assign interrupt = r_interrupt;
    assign if_valid  = r_if_valid;
    assign int_en    = r_int_en;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model returns word=address,
// scoreboard of expected IF/ID slots, plus directed cycle checks.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_in, branch_sel, irq, returni;
    logic [31:0] branch_pc;
    logic        imem_req, imem_valid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pc_plus_4, instr;
    logic        interrupt, if_valid, int_en;

    logic        req2, valid2, intr2, ifv2, inten2;
    logic [31:0] addr2, rdata2, pc4_2, instr2;

    int          lat;
    logic        mem_off;
    int          cnt;
    logic        prev_stall = 1'b0;

    int          n_total = 0;
    int          n_bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        intr;
    } exp_t;
    exp_t        sb_q[$];
    exp_t        e;

    always #5 clk = ~clk;

    instr_fetch u_dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .branch_sel(branch_sel),
        .branch_pc(branch_pc), .irq(irq), .returni(returni),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid), .pc_plus_4(pc_plus_4), .instr(instr),
        .interrupt(interrupt), .if_valid(if_valid), .int_en(int_en)
    );

    instr_fetch #(.RESET_VEC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .branch_sel(branch_sel),
        .branch_pc(branch_pc), .irq(irq), .returni(returni),
        .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2),
        .imem_valid(valid2), .pc_plus_4(pc4_2), .instr(instr2),
        .interrupt(intr2), .if_valid(ifv2), .int_en(inten2)
    );

    // Memory model: word equals address, response after 'lat' waiting cycles.
    assign imem_valid = imem_req && !mem_off && (cnt >= lat);
    assign imem_rdata = imem_addr;
    assign valid2     = req2;
    assign rdata2     = addr2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 0;
        else if (imem_req && !imem_valid) cnt <= cnt + 1;
        else cnt <= 0;
    end

    always @(posedge clk) prev_stall <= stall_in;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every new valid IF/ID slot must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && if_valid && !prev_stall) begin
            chk_eq("sb_avail", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk_eq("sb_instr", instr, e.instr);
                chk_eq("sb_pc4", pc_plus_4, e.pc4);
                chk_eq("sb_intr", {31'd0, interrupt}, {31'd0, e.intr});
            end
        end
    end

    task automatic push_norm(input logic [31:0] a);
        exp_t x;
        x.instr = a; x.pc4 = a + 32'd4; x.intr = 1'b0;
        sb_q.push_back(x);
    endtask

    task automatic push_int(input logic [31:0] ret);
        exp_t x;
        x.instr = 32'h0000_0000; x.pc4 = ret; x.intr = 1'b1;
        sb_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        rst_n = 1'b0;
        stall_in = 1'b0; branch_sel = 1'b0; branch_pc = 32'd0;
        irq = 1'b0; returni = 1'b0;
        lat = l; mem_off = 1'b0;
        sb_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        chk_eq(tag, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        // Zero-wait memory: one instruction per cycle.
        do_reset(0);
        chk_eq("rst_addr", imem_addr, 32'h0);
        chk_eq("rst_req", {31'd0, imem_req}, 32'd0);
        chk_eq("rst_ifv", {31'd0, if_valid}, 32'd0);
        chk_eq("rst_inten", {31'd0, int_en}, 32'd1);
        chk_eq("rst_pc4", pc_plus_4, 32'd0);
        push_norm(32'h0); push_norm(32'h4); push_norm(32'h8);
        tick();
        chk_eq("s1_addr0", imem_addr, 32'h0);
        chk_eq("s1_req", {31'd0, imem_req}, 32'd1);
        chk_eq("s1_ifv0", {31'd0, if_valid}, 32'd0);
        tick();
        chk_eq("s1_addr1", imem_addr, 32'h4);
        chk_eq("s1_ifv1", {31'd0, if_valid}, 32'd1);
        tick();
        chk_eq("s1_addr2", imem_addr, 32'h8);
        tick();
        mem_off = 1'b1;
        tick();
        drain("s1_drain");

        // Three waiting cycles before the first response.
        do_reset(3);
        push_norm(32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_eq("s2_addr", imem_addr, 32'h0);
            chk_eq("s2_bubble", {31'd0, if_valid}, 32'd0);
        end
        tick();
        chk_eq("s2_instr", instr, 32'h0);
        chk_eq("s2_pc4", pc_plus_4, 32'h4);
        mem_off = 1'b1;
        tick();
        drain("s2_drain");

        // Stall asserted together with the response for address 8.
        do_reset(0);
        push_norm(32'h0); push_norm(32'h4); push_norm(32'h8);
        repeat (3) tick();
        stall_in = 1'b1;
        tick();
        chk_eq("s3_req_a", {31'd0, imem_req}, 32'd0);
        chk_eq("s3_hold_a", instr, 32'h4);
        tick();
        chk_eq("s3_req_b", {31'd0, imem_req}, 32'd0);
        chk_eq("s3_hold_b", instr, 32'h4);
        stall_in = 1'b0;
        tick();
        chk_eq("s3_instr", instr, 32'h8);
        chk_eq("s3_pc4", pc_plus_4, 32'hC);
        chk_eq("s3_req_c", {31'd0, imem_req}, 32'd1);
        mem_off = 1'b1;
        tick();
        drain("s3_drain");

        // Branch to 0x40 while the fetch of 0x10 is outstanding.
        do_reset(0);
        push_norm(32'h0); push_norm(32'h4); push_norm(32'h8); push_norm(32'hC);
        push_norm(32'h40);
        repeat (5) tick();
        lat = 2;
        branch_sel = 1'b1; branch_pc = 32'h40;
        tick();
        branch_sel = 1'b0;
        chk_eq("s4_addr_hold", imem_addr, 32'h10);
        chk_eq("s4_bubble", {31'd0, if_valid}, 32'd0);
        tick();
        chk_eq("s4_addr_hold2", imem_addr, 32'h10);
        tick();
        chk_eq("s4_redirect", imem_addr, 32'h40);
        chk_eq("s4_bubble2", {31'd0, if_valid}, 32'd0);
        lat = 0;
        tick();
        chk_eq("s4_instr", instr, 32'h40);
        chk_eq("s4_pc4", pc_plus_4, 32'h44);
        mem_off = 1'b1;
        tick();
        drain("s4_drain");

        // Interrupt at 0x20, masked until returni, then taken again.
        do_reset(0);
        for (int a = 0; a < 32; a += 4) push_norm(32'(a));
        push_int(32'h20);
        push_norm(32'h10); push_norm(32'h14); push_norm(32'h18);
        push_int(32'h1C);
        repeat (9) tick();
        irq = 1'b1;
        tick();
        chk_eq("s5_intr", {31'd0, interrupt}, 32'd1);
        chk_eq("s5_ret", pc_plus_4, 32'h20);
        chk_eq("s5_vec", imem_addr, 32'h10);
        chk_eq("s5_inten0", {31'd0, int_en}, 32'd0);
        chk_eq("s5_nop", instr, 32'h0);
        tick();
        chk_eq("s5_masked", {31'd0, interrupt}, 32'd0);
        tick();
        returni = 1'b1;
        tick();
        returni = 1'b0;
        chk_eq("s5_inten1", {31'd0, int_en}, 32'd1);
        chk_eq("s5_oldinten", {31'd0, interrupt}, 32'd0);
        tick();
        chk_eq("s5_intr2", {31'd0, interrupt}, 32'd1);
        chk_eq("s5_ret2", pc_plus_4, 32'h1C);
        chk_eq("s5_vec2", imem_addr, 32'h10);
        irq = 1'b0;
        mem_off = 1'b1;
        tick();
        drain("s5_drain");

        // Asynchronous reset while a request is waiting.
        #2 rst_n = 1'b0;
        #1;
        chk_eq("ar_req", {31'd0, imem_req}, 32'd0);
        chk_eq("ar_addr", imem_addr, 32'h0);
        chk_eq("ar_inten", {31'd0, int_en}, 32'd1);
        chk_eq("ar_pc4", pc_plus_4, 32'h0);
        chk_eq("ar_ifv", {31'd0, if_valid}, 32'd0);
        chk_eq("ar_intr", {31'd0, interrupt}, 32'd0);

        // Reset vector at the top of the address space wraps to 0.
        do_reset(0);
        mem_off = 1'b1;
        chk_eq("w_rst_addr", addr2, 32'hFFFF_FFFC);
        tick();
        chk_eq("w_addr0", addr2, 32'hFFFF_FFFC);
        chk_eq("w_req", {31'd0, req2}, 32'd1);
        tick();
        chk_eq("w_addr1", addr2, 32'h0);
        chk_eq("w_instr0", instr2, 32'hFFFF_FFFC);
        chk_eq("w_pc4_0", pc4_2, 32'h0);
        chk_eq("w_ifv", {31'd0, ifv2}, 32'd1);
        tick();
        chk_eq("w_addr2", addr2, 32'h4);
        chk_eq("w_instr1", instr2, 32'h0);
        chk_eq("w_pc4_1", pc4_2, 32'h4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It produces the pc_plus_4 / instr / interrupt bundle that the decode stage consumes, and it consumes the branch_pc / branch_sel redirect that the decode stage produces. It issues requests to instruction memory through a single-outstanding req/valid handshake. It also takes external interrupts at instruction boundaries, and re-enables them when decode signals a return-from-interrupt.

Parameters:
RESET_VEC, 32'h0000_0000, PC of the first fetch after reset.
INT_VEC, 32'h0000_0010, fetch address taken on interrupt entry.
NOP_INSTR, 32'h0000_0000, encoding loaded into instr for every bubble.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
stall_in  in  1  hazard stall; hold the IF/ID register and the fetch result.
branch_sel  in  1  redirect request from decode.
branch_pc  in  32  redirect target.
irq  in  1  level-sensitive external interrupt.
returni  in  1  one-cycle pulse from decode; re-enables interrupts.
imem_req  out  1  instruction memory request.
imem_addr  out  32  fetch address; registered, stable while imem_req is high and imem_valid is low.
imem_rdata  in  32  fetched word; sampled only when imem_valid=1.
imem_valid  in  1  response; may arrive in the same cycle as imem_req or later.
pc_plus_4  out  32  IF/ID: address+4 of the delivered instruction, or the return address on interrupt.
instr  out  32  IF/ID instruction word.
interrupt  out  1  IF/ID: the bundle is an interrupt-entry bubble.
if_valid  out  1  IF/ID holds a real slot (instruction or interrupt entry).
int_en  out  1  interrupt enable flag.

Behaviour:
- Reset (asynchronous): state=IDLE, imem_req=0, imem_addr=RESET_VEC, instr=NOP_INSTR, pc_plus_4=0, interrupt=0, if_valid=0, int_en=1, redirect_pending=0.
- States:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH: imem_req=1.
  - HOLD: imem_req=0; a word has been captured but not yet delivered.
- Branch taken = branch_sel && !stall_in. Priority: reset > branch taken > interrupt > stall > normal delivery.
- Delivery point: in FETCH with imem_valid=1, or in HOLD with stall_in=0, and no redirect pending or taken.
- Normal delivery:
  - IF/ID <= {instr=word, pc_plus_4=imem_addr+4, interrupt=0, if_valid=1}.
  - imem_addr <= imem_addr+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
  - Next state FETCH.
  - Zero-wait memory therefore sustains one instruction per cycle.
- FETCH with imem_valid=1 and stall_in=1 and no branch: capture imem_rdata into the hold register, go to HOLD, IF/ID unchanged.
- Stall with no delivery: IF/ID holds its value.
- No stall and no delivery: IF/ID <= bubble (instr=NOP_INSTR, if_valid=0, interrupt=0).
- Branch taken:
  - IF/ID <= bubble.
  - If no request is outstanding, or imem_valid=1 this cycle: discard any word, imem_addr <= branch_pc, next state FETCH.
  - If in FETCH with imem_valid=0: redirect_pending <= 1 and redirect_pc <= branch_pc; imem_addr stays stable.
  - A later branch while pending overwrites redirect_pc.
- Response while redirect_pending: discard the word, imem_addr <= redirect_pc, clear pending, stay in FETCH, IF/ID gets a bubble.
- Interrupt taken at a delivery point when irq && int_en:
  - The fetched word is discarded.
  - IF/ID <= {instr=NOP_INSTR, pc_plus_4=imem_addr (return address), interrupt=1, if_valid=1}.
  - imem_addr <= INT_VEC; int_en <= 0; next state FETCH.
- returni=1: int_en <= 1 at the next edge. An interrupt decision in the same cycle uses the old int_en.
- irq held while int_en=0 is ignored. It is taken at the first delivery point after re-enable.
- Reset mid-transaction: the outstanding request is abandoned. imem_valid in IDLE or HOLD is ignored.

Test Plan:
- Reset release, zero-wait memory returning word=addr: imem_addr sequence 0,4,8; instr=0,4,8 with pc_plus_4=4,8,C and if_valid=1 every cycle from the second cycle after reset.
- 3-cycle memory latency: imem_addr holds 0 for 3 cycles and the IF/ID register shows bubbles; then instr=word@0, pc_plus_4=4.
- stall_in=1 for 2 cycles, asserted in the same cycle as imem_valid=1 (addr 8): IF/ID holds; the word is delivered in the first cycle after stall_in drops, with no extra imem_req.
- Branch to 32'h40 while a fetch of 0x10 is pending: the 0x10 response is dropped, the next request is 0x40, IF/ID shows a bubble, and no instr from 0x10 ever appears with if_valid=1.
- Hold irq at fetch of 0x20 with int_en=1: interrupt=1, pc_plus_4=32'h20, next imem_addr=0x10, int_en=0. A second irq is ignored until a returni pulse, then taken.
- Start at RESET_VEC=32'hFFFF_FFFC: the second fetch address is 0. Assert rst_n=0 mid-wait: outputs return to reset values asynchronously.
